rc4_prga_decrypt: RTL and testbench

Parametrised RC4 keystream-generation (PRGA) and decrypt engine for the lab4 key-search datapath. It runs after the key-scheduling pass has left a permuted S array in the S RAM. It walks the encrypted ROM for `MSG_LEN` bytes, XORs each byte with the keystream and writes the result to the decrypted RAM. Each plaintext byte is optionally checked against the valid character set. The controller uses `key_found` to accept the current key or advance to the next one.

---
 rtl/rc4_prga_decrypt.sv | 193 +++++++++++++++++++
 tb/tb_rc4_prga_decrypt.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rc4_prga_decrypt.sv
// RC4 PRGA keystream and decrypt engine: walks the encrypted ROM, XORs each byte with the
// keystream drawn from the S RAM and writes the plaintext. Optional macro: RC4_CHAR_CHECK_EN.
module rc4_prga_decrypt #(
    parameter int MSG_LEN = 32,
    parameter int RD_LAT  = 2,
    parameter int AW      = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          key_found,
    output logic [7:0]    s_addr,
    output logic [7:0]    s_wdata,
    input  logic [7:0]    s_rdata,
    output logic          s_wren,
    output logic [AW-1:0] e_addr,
    input  logic [7:0]    e_rdata,
    output logic [AW-1:0] d_addr,
    output logic [7:0]    d_wdata,
    output logic          d_wren
);

    localparam int            WW        = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [WW-1:0] LAST_WAIT = WW'(RD_LAT - 1);
    localparam logic [AW-1:0] LAST_K    = AW'(MSG_LEN - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_RD_I,
        S_WAIT_I,
        S_RD_J,
        S_WAIT_J,
        S_WR_I,
        S_WR_J,
        S_RD_F,
        S_WAIT_F,
        S_WR_D,
        S_CHECK,
        S_DONE
    } state_t;

    state_t        state_q;
    logic [7:0]    i_q, j_q, si_q, sj_q;
    logic [AW-1:0] k_q;
    logic [WW-1:0] wait_q;
    logic          busy_q, done_q, key_found_q;
    logic [7:0]    s_addr_q, s_wdata_q, d_wdata_q;
    logic [AW-1:0] e_addr_q, d_addr_q;

    logic [7:0]    i_d, j_d, f_addr_d;
    logic          wait_last;
    logic          byte_ok;

    assign i_d       = i_q + 8'd1;
    assign j_d       = j_q + si_q;
    assign f_addr_d  = si_q + sj_q;
    assign wait_last = (wait_q == LAST_WAIT);

`ifdef RC4_CHAR_CHECK_EN
    assign byte_ok = ((d_wdata_q >= 8'h61) && (d_wdata_q <= 8'h7A)) || (d_wdata_q == 8'h20);
`else
    assign byte_ok = 1'b1;
`endif

    // NOTE: write enables decode the state directly so they line up with the address registered on entry.
    assign s_wren = (state_q == S_WR_I) || (state_q == S_WR_J);
    assign d_wren = (state_q == S_WR_D);

    assign busy      = busy_q;
    assign done      = done_q;
    assign key_found = key_found_q;
    assign s_addr    = s_addr_q;
    assign s_wdata   = s_wdata_q;
    assign e_addr    = e_addr_q;
    assign d_addr    = d_addr_q;
    assign d_wdata   = d_wdata_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            i_q         <= '0;
            j_q         <= '0;
            si_q        <= '0;
            sj_q        <= '0;
            k_q         <= '0;
            wait_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            key_found_q <= 1'b0;
            s_addr_q    <= '0;
            s_wdata_q   <= '0;
            e_addr_q    <= '0;
            d_addr_q    <= '0;
            d_wdata_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        i_q         <= '0;
                        j_q         <= '0;
                        k_q         <= '0;
                        key_found_q <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= S_RD_I;
                    end
                end
                S_RD_I: begin
                    i_q      <= i_d;
                    s_addr_q <= i_d;
                    wait_q   <= '0;
                    state_q  <= S_WAIT_I;
                end
                S_WAIT_I: begin
                    if (wait_last) begin
                        si_q    <= s_rdata;
                        state_q <= S_RD_J;
                    end else begin
                        wait_q <= wait_q + WW'(1);
                    end
                end
                S_RD_J: begin
                    j_q      <= j_d;
                    s_addr_q <= j_d;
                    wait_q   <= '0;
                    state_q  <= S_WAIT_J;
                end
                S_WAIT_J: begin
                    // Stage the S[i] <- sj write so it is on the bus during WR_I.
                    if (wait_last) begin
                        sj_q      <= s_rdata;
                        s_addr_q  <= i_q;
                        s_wdata_q <= s_rdata;
                        state_q   <= S_WR_I;
                    end else begin
                        wait_q <= wait_q + WW'(1);
                    end
                end
                S_WR_I: begin
                    s_addr_q  <= j_q;
                    s_wdata_q <= si_q;
                    state_q   <= S_WR_J;
                end
                S_WR_J: begin
                    state_q <= S_RD_F;
                end
                S_RD_F: begin
                    s_addr_q <= f_addr_d;
                    e_addr_q <= k_q;
                    wait_q   <= '0;
                    state_q  <= S_WAIT_F;
                end
                S_WAIT_F: begin
                    if (wait_last) begin
                        d_addr_q  <= k_q;
                        d_wdata_q <= s_rdata ^ e_rdata;
                        state_q   <= S_WR_D;
                    end else begin
                        wait_q <= wait_q + WW'(1);
                    end
                end
                S_WR_D: begin
                    state_q <= S_CHECK;
                end
                S_CHECK: begin
                    if (!byte_ok) begin
                        key_found_q <= 1'b0;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        state_q     <= S_DONE;
                    end else if (k_q == LAST_K) begin
                        key_found_q <= 1'b1;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        state_q     <= S_DONE;
                    end else begin
                        k_q     <= k_q + AW'(1);
                        state_q <= S_RD_I;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rc4_prga_decrypt.sv
// Self-checking bench for rc4_prga_decrypt: three instances (RD_LAT 1, 2, 3) run in lockstep
// against behavioural S/e/d memories and a plain RC4 reference model.
module tb_rc4_prga_decrypt;

    localparam int MSG_LEN = 32;
    localparam int AW      = $clog2(MSG_LEN);
    localparam int NI      = 3;
    localparam int BUDGET  = 700;
`ifdef RC4_CHAR_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    typedef struct {
        logic [7:0] e0;
        logic [7:0] d0;
    } vec_t;

    logic          clk     = 1'b0;
    logic          reset   = 1'b0;
    logic          start   = 1'b0;
    logic          preload = 1'b0;
    logic [NI-1:0] busy, done, key_found, s_wren, d_wren;
    logic [7:0]    s_addr [NI];
    logic [7:0]    s_wdata[NI];
    logic [7:0]    s_rdata[NI];
    logic [7:0]    e_rdata[NI];
    logic [7:0]    d_wdata[NI];
    logic [AW-1:0] e_addr [NI];
    logic [AW-1:0] d_addr [NI];

    logic [7:0] s_mem [NI][256];
    logic [7:0] d_mem [NI][MSG_LEN];
    logic [7:0] s_pipe[NI][2];
    logic [7:0] e_pipe[NI][2];
    logic [7:0] s_init[256];
    logic [7:0] e_mem [MSG_LEN];
    logic [7:0] plain [MSG_LEN];

    logic [7:0] exp_d[MSG_LEN];
    logic [7:0] exp_s[256];
    int         exp_n;
    bit         exp_found;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        rc4_prga_decrypt #(
            .MSG_LEN(MSG_LEN),
            .RD_LAT (g + 1),
            .AW     (AW)
        ) u_dut (
            .clk      (clk),
            .reset    (reset),
            .start    (start),
            .busy     (busy[g]),
            .done     (done[g]),
            .key_found(key_found[g]),
            .s_addr   (s_addr[g]),
            .s_wdata  (s_wdata[g]),
            .s_rdata  (s_rdata[g]),
            .s_wren   (s_wren[g]),
            .e_addr   (e_addr[g]),
            .e_rdata  (e_rdata[g]),
            .d_addr   (d_addr[g]),
            .d_wdata  (d_wdata[g]),
            .d_wren   (d_wren[g])
        );
    end

    // Memories: read data appears RD_LAT cycles after the DUT's registered address.
    always @(posedge clk) begin
        for (int g = 0; g < NI; g++) begin
            if (preload) begin
                for (int x = 0; x < 256; x++) s_mem[g][x] <= s_init[x];
                for (int x = 0; x < MSG_LEN; x++) d_mem[g][x] <= 8'hA5;
            end else begin
                if (s_wren[g]) s_mem[g][s_addr[g]] <= s_wdata[g];
                if (d_wren[g]) d_mem[g][d_addr[g]] <= d_wdata[g];
            end
            s_pipe[g][0] <= s_mem[g][s_addr[g]];
            s_pipe[g][1] <= s_pipe[g][0];
            e_pipe[g][0] <= e_mem[e_addr[g]];
            e_pipe[g][1] <= e_pipe[g][0];
        end
    end

    assign s_rdata[0] = s_mem[0][s_addr[0]];
    assign s_rdata[1] = s_pipe[1][0];
    assign s_rdata[2] = s_pipe[2][1];
    assign e_rdata[0] = e_mem[e_addr[0]];
    assign e_rdata[1] = e_pipe[1][0];
    assign e_rdata[2] = e_pipe[2][1];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic bit char_ok(input logic [7:0] b);
        return ((b >= 8'h61) && (b <= 8'h7A)) || (b == 8'h20);
    endfunction

    function automatic logic [63:0] out_word(input int g);
        return {25'd0, busy[g], done[g], key_found[g], s_wren[g], d_wren[g],
                s_addr[g], s_wdata[g], e_addr[g], d_addr[g], d_wdata[g]};
    endfunction

    // Plain RC4 PRGA over a copy of s_init; stops after the first rejected byte when checking.
    task automatic model_run(input bit use_check);
        logic [7:0] s[256];
        logic [7:0] t;
        int i = 0;
        int j = 0;
        for (int x = 0; x < 256; x++) s[x] = s_init[x];
        for (int x = 0; x < MSG_LEN; x++) exp_d[x] = 8'hA5;
        exp_n     = MSG_LEN;
        exp_found = 1'b1;
        for (int k = 0; k < MSG_LEN; k++) begin
            i    = (i + 1) % 256;
            j    = (j + int'(s[i])) % 256;
            t    = s[i];
            s[i] = s[j];
            s[j] = t;
            exp_d[k] = e_mem[k] ^ s[(int'(s[i]) + int'(s[j])) % 256];
            if (use_check && !char_ok(exp_d[k])) begin
                exp_n     = k + 1;
                exp_found = 1'b0;
                break;
            end
        end
        for (int x = 0; x < 256; x++) exp_s[x] = s[x];
    endtask

    task automatic ksa_random();
        logic [7:0] key[16];
        logic [7:0] t;
        int klen = int'($urandom_range(16, 3));
        int j = 0;
        for (int x = 0; x < 16; x++) key[x] = 8'($urandom);
        for (int x = 0; x < 256; x++) s_init[x] = 8'(x);
        for (int x = 0; x < 256; x++) begin
            j         = (j + int'(s_init[x]) + int'(key[x % klen])) % 256;
            t         = s_init[x];
            s_init[x] = s_init[j];
            s_init[j] = t;
        end
    endtask

    // Builds e so the plaintext is valid text, with one uppercase byte at bad_pos (-1: none).
    task automatic build_message(input int bad_pos);
        int r;
        for (int k = 0; k < MSG_LEN; k++) e_mem[k] = 8'h00;
        model_run(1'b0);
        for (int k = 0; k < MSG_LEN; k++) begin
            r = int'($urandom_range(26, 0));
            plain[k] = (r == 26) ? 8'h20 : 8'(8'h61 + r);
            if (k == bad_pos) plain[k] = 8'(8'h41 + $urandom_range(25, 0));
            e_mem[k] = plain[k] ^ exp_d[k];
        end
    endtask

    task automatic do_preload();
        @(negedge clk);
        preload = 1'b1;
        @(negedge clk);
        preload = 1'b0;
    endtask

    task automatic run_and_check(input string tag, input int extra_start);
        bit         seen[NI];
        int         dcyc[NI];
        int         viol[NI];
        int         post[NI];
        logic       kf[NI];
        int         cyc;
        int         mism;
        bit         all_done;
        do_preload();
        model_run(CHECK_EN);
        for (int g = 0; g < NI; g++) begin
            seen[g] = 1'b0; dcyc[g] = -1; viol[g] = 0; post[g] = 0; kf[g] = 1'bx;
        end
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        all_done = 1'b0;
        while (cyc <= BUDGET && !all_done) begin
            all_done = 1'b1;
            for (int g = 0; g < NI; g++) begin
                if (s_wren[g] && d_wren[g]) viol[g]++;
                if (!seen[g]) begin
                    if (done[g] === 1'b1) begin
                        seen[g] = 1'b1;
                        dcyc[g] = cyc;
                        kf[g]   = key_found[g];
                        if (busy[g] !== 1'b0) viol[g]++;
                    end else begin
                        if (busy[g] !== 1'b1) viol[g]++;
                        if (key_found[g] !== 1'b0) viol[g]++;
                    end
                end else begin
                    post[g]++;
                    if (done[g] !== 1'b0 || busy[g] !== 1'b0) viol[g]++;
                    if (key_found[g] !== kf[g]) viol[g]++;
                end
                if (!seen[g] || post[g] < 2) all_done = 1'b0;
            end
            start = (cyc == extra_start);
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        for (int g = 0; g < NI; g++) begin
            check($sformatf("%s_lat%0d_done_cycle", tag, g + 1), 64'(dcyc[g]),
                  64'(exp_n * (3 * (g + 2) + 4) + 1));
            check($sformatf("%s_lat%0d_key_found", tag, g + 1), 64'(kf[g]), 64'(exp_found));
            check($sformatf("%s_lat%0d_protocol", tag, g + 1), 64'(viol[g]), 64'd0);
            mism = 0;
            for (int k = 0; k < MSG_LEN; k++) if (d_mem[g][k] !== exp_d[k]) mism++;
            check($sformatf("%s_lat%0d_dram_mismatches", tag, g + 1), 64'(mism), 64'd0);
            mism = 0;
            for (int x = 0; x < 256; x++) if (s_mem[g][x] !== exp_s[x]) mism++;
            check($sformatf("%s_lat%0d_sram_mismatches", tag, g + 1), 64'(mism), 64'd0);
        end
    endtask

    initial begin
        vec_t vecs[6];
        int   idle_viol;
        int   mism;

        // Identity S: i=j=1, swap is a no-op, f=S[2]=2, so d[0]=e[0]^0x02.
        vecs[0] = '{8'h63, 8'h61};
        vecs[1] = '{8'h00, 8'h02};
        vecs[2] = '{8'h22, 8'h20};
        vecs[3] = '{8'h78, 8'h7A};
        vecs[4] = '{8'h62, 8'h60};
        vecs[5] = '{8'h79, 8'h7B};

        #1 reset = 1'b1;
        repeat (3) @(negedge clk);
        for (int g = 0; g < NI; g++) check($sformatf("reset_outputs_lat%0d", g + 1), out_word(g), 64'd0);
        reset = 1'b0;

        for (int v = 0; v < 6; v++) begin
            for (int x = 0; x < 256; x++) s_init[x] = 8'(x);
            e_mem[0] = vecs[v].e0;
            for (int k = 1; k < MSG_LEN; k++) e_mem[k] = 8'($urandom);
            run_and_check($sformatf("vec%0d", v), 0);
            for (int g = 0; g < NI; g++)
                check($sformatf("vec%0d_lat%0d_d0", v, g + 1), 64'(d_mem[g][0]), 64'(vecs[v].d0));
        end

        // Full valid message with a stray start pulse while busy.
        ksa_random();
        build_message(-1);
        run_and_check("valid_msg", 50);
        for (int g = 0; g < NI; g++) begin
            mism = 0;
            for (int k = 0; k < MSG_LEN; k++) if (d_mem[g][k] !== plain[k]) mism++;
            check($sformatf("valid_msg_lat%0d_plaintext", g + 1), 64'(mism), 64'd0);
        end

        for (int r = 0; r < 2; r++) begin
            ksa_random();
            build_message(int'($urandom_range(MSG_LEN - 1, 1)));
            run_and_check($sformatf("late_abort%0d", r), 0);
        end

        for (int r = 0; r < 2; r++) begin
            ksa_random();
            for (int k = 0; k < MSG_LEN; k++) e_mem[k] = 8'($urandom);
            run_and_check($sformatf("random%0d", r), 0);
        end

        // Reset in the middle of a run.
        ksa_random();
        build_message(-1);
        do_preload();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (99) @(negedge clk);
        check("busy_before_reset", 64'(busy), 64'(3'b111));
        reset = 1'b1;
        #1;
        for (int g = 0; g < NI; g++) check($sformatf("midrun_reset_lat%0d", g + 1), out_word(g), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        idle_viol = 0;
        repeat (5) begin
            @(negedge clk);
            if (busy !== '0 || done !== '0 || s_wren !== '0 || d_wren !== '0) idle_viol++;
        end
        check("idle_after_reset", 64'(idle_viol), 64'd0);
        run_and_check("after_reset", 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
